// File: rtl/rob_buffer.sv
// Reorder buffer: in-order allocate, out-of-order completion over NUM_CPL
// writeback channels, in-order commit, and a full squash on flush.

module rob_entry #(
  parameter int PREG_W  = 6,
  parameter int PC_W    = 32,
  parameter int NUM_CPL = 2,
  parameter int TAG_W   = 6,
  parameter int IDX     = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     alloc_we,
  input  logic                     commit_clr,
  input  logic [NUM_CPL-1:0]       cpl_valid,
  input  logic [NUM_CPL*TAG_W-1:0] cpl_tag,
  input  logic [PREG_W-1:0]        alloc_destreg,
  input  logic [PREG_W-1:0]        alloc_old_destreg,
  input  logic [PC_W-1:0]          alloc_pc,
  output logic                     used,
  output logic                     completed,
  output logic [PREG_W-1:0]        destreg,
  output logic [PREG_W-1:0]        old_destreg,
  output logic [PC_W-1:0]          pc
);

  logic cpl_hit;

  // Any channel naming this slot; duplicates collapse to a single hit.
  always_comb begin
    cpl_hit = 1'b0;
    for (int i = 0; i < NUM_CPL; i++)
      if (cpl_valid[i] && cpl_tag[i*TAG_W +: TAG_W] == TAG_W'(IDX))
        cpl_hit = 1'b1;
  end

  // Completions to a slot that is not in use are stale and dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      used      <= 1'b0;
      completed <= 1'b0;
    end else if (flush) begin
      used      <= 1'b0;
      completed <= 1'b0;
    end else if (alloc_we) begin
      used      <= 1'b1;
      completed <= 1'b0;
    end else if (commit_clr) begin
      used      <= 1'b0;
      completed <= 1'b0;
    end else if (cpl_hit && used) begin
      completed <= 1'b1;
    end
  end

  // Payload is qualified by used, so it carries no reset.
  always_ff @(posedge clk) begin
    if (alloc_we && !flush) begin
      destreg     <= alloc_destreg;
      old_destreg <= alloc_old_destreg;
      pc          <= alloc_pc;
    end
  end

endmodule

module rob_buffer #(
  parameter int DEPTH   = 64,
  parameter int PREG_W  = 6,
  parameter int PC_W    = 32,
  parameter int NUM_CPL = 2,
  localparam int TAG_W  = $clog2(DEPTH),
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     alloc_valid,
  output logic                     alloc_ready,
  input  logic [PREG_W-1:0]        alloc_destreg,
  input  logic [PREG_W-1:0]        alloc_old_destreg,
  input  logic [PC_W-1:0]          alloc_pc,
  output logic [TAG_W-1:0]         alloc_tag,
  input  logic [NUM_CPL-1:0]       cpl_valid,
  input  logic [NUM_CPL*TAG_W-1:0] cpl_tag,
  output logic                     commit_valid,
  input  logic                     commit_ready,
  output logic [PREG_W-1:0]        commit_destreg,
  output logic [PREG_W-1:0]        commit_old_destreg,
  output logic [PC_W-1:0]          commit_pc,
  output logic [CNT_W-1:0]         count,
  output logic                     full,
  output logic                     empty
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [TAG_W-1:0]               head, tail;
  logic [DEPTH-1:0]               used, completed;
  logic [DEPTH-1:0][PREG_W-1:0]   destreg, old_destreg;
  logic [DEPTH-1:0][PC_W-1:0]     pc;
  logic                           alloc_fire, commit_fire;

  assign full        = (count == FULL_CNT);
  assign empty       = (count == '0);
  assign alloc_ready = !full;
  assign alloc_tag   = tail;
  assign alloc_fire  = alloc_valid && alloc_ready;

  assign commit_valid       = used[head] && completed[head];
  assign commit_fire        = commit_valid && commit_ready;
  assign commit_destreg     = commit_valid ? destreg[head]     : '0;
  assign commit_old_destreg = commit_valid ? old_destreg[head] : '0;
  assign commit_pc          = commit_valid ? pc[head]          : '0;

  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    rob_entry #(
      .PREG_W (PREG_W),
      .PC_W   (PC_W),
      .NUM_CPL(NUM_CPL),
      .TAG_W  (TAG_W),
      .IDX    (g)
    ) u_ent (
      .clk              (clk),
      .rst              (rst),
      .flush            (flush),
      .alloc_we         (alloc_fire && tail == TAG_W'(g)),
      .commit_clr       (commit_fire && head == TAG_W'(g)),
      .cpl_valid        (cpl_valid),
      .cpl_tag          (cpl_tag),
      .alloc_destreg    (alloc_destreg),
      .alloc_old_destreg(alloc_old_destreg),
      .alloc_pc         (alloc_pc),
      .used             (used[g]),
      .completed        (completed[g]),
      .destreg          (destreg[g]),
      .old_destreg      (old_destreg[g]),
      .pc               (pc[g])
    );
  end

  // Pointers wrap at DEPTH because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (alloc_fire)  tail <= tail + 1'b1;
      if (commit_fire) head <= head + 1'b1;
      case ({alloc_fire, commit_fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_rob_buffer.sv
// Directed bench for rob_buffer (DEPTH=64, two completion channels).

module tb_rob_buffer;

  localparam int DEPTH = 64, PREG_W = 6, PC_W = 32, NUM_CPL = 2, TAG_W = 6, CNT_W = 7;

  logic                     clk = 1'b0;
  logic                     rst, flush, alloc_valid, commit_ready;
  logic                     alloc_ready, commit_valid, full, empty;
  logic [PREG_W-1:0]        alloc_destreg, alloc_old_destreg, commit_destreg, commit_old_destreg;
  logic [PC_W-1:0]          alloc_pc, commit_pc;
  logic [TAG_W-1:0]         alloc_tag;
  logic [NUM_CPL-1:0]       cpl_valid;
  logic [NUM_CPL*TAG_W-1:0] cpl_tag;
  logic [CNT_W-1:0]         count;

  int checks = 0;
  int failures = 0;

  rob_buffer #(.DEPTH(DEPTH), .PREG_W(PREG_W), .PC_W(PC_W), .NUM_CPL(NUM_CPL)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
    .alloc_destreg(alloc_destreg), .alloc_old_destreg(alloc_old_destreg),
    .alloc_pc(alloc_pc), .alloc_tag(alloc_tag),
    .cpl_valid(cpl_valid), .cpl_tag(cpl_tag),
    .commit_valid(commit_valid), .commit_ready(commit_ready),
    .commit_destreg(commit_destreg), .commit_old_destreg(commit_old_destreg),
    .commit_pc(commit_pc), .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic alloc(input logic [PREG_W-1:0] d, input logic [PREG_W-1:0] od, input logic [PC_W-1:0] p);
    alloc_valid = 1'b1; alloc_destreg = d; alloc_old_destreg = od; alloc_pc = p;
    tick();
    alloc_valid = 1'b0;
  endtask

  task automatic cpl1(input logic [TAG_W-1:0] t);
    cpl_valid = 2'b01; cpl_tag = {6'd0, t};
    tick();
    cpl_valid = 2'b00;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; alloc_valid = 1'b0; commit_ready = 1'b0;
    alloc_destreg = '0; alloc_old_destreg = '0; alloc_pc = '0;
    cpl_valid = '0; cpl_tag = '0;
    #2;
    chk("rst_ready", alloc_ready, 1);
    chk("rst_tag", alloc_tag, 0);
    chk("rst_cvalid", commit_valid, 0);
    chk("rst_cpc", commit_pc, 0);
    chk("rst_count", count, 0);
    chk("rst_full", full, 0);
    chk("rst_empty", empty, 1);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    tick();

    // 1: fill
    for (int n = 0; n < DEPTH; n++) begin
      chk("fill_tag", alloc_tag, 64'(n));
      chk("fill_ready", alloc_ready, 1);
      alloc(6'(n), ~6'(n), 32'h100 + 32'(4 * n));
    end
    chk("fill_full", full, 1);
    chk("fill_ready0", alloc_ready, 0);
    chk("fill_count", count, 64);
    chk("fill_cvalid", commit_valid, 0);
    flush = 1'b1; tick(); flush = 1'b0;
    chk("flush1_empty", empty, 1);

    // 2: out-of-order completion
    alloc(6'd1, 6'd31, 32'h200);
    alloc(6'd2, 6'd32, 32'h204);
    alloc(6'd3, 6'd33, 32'h208);
    cpl1(6'd2);
    chk("ooo_after2", commit_valid, 0);
    cpl1(6'd1);
    chk("ooo_after1", commit_valid, 0);
    cpl1(6'd0);
    chk("ooo_after0", commit_valid, 1);
    chk("ooo_pc0", commit_pc, 32'h200);
    chk("ooo_dst0", commit_destreg, 1);
    commit_ready = 1'b1;
    tick();
    chk("ooo_v1", commit_valid, 1);
    chk("ooo_pc1", commit_pc, 32'h204);
    tick();
    chk("ooo_pc2", commit_pc, 32'h208);
    tick();
    commit_ready = 1'b0;
    chk("ooo_empty", empty, 1);
    chk("ooo_cvalid0", commit_valid, 0);
    chk("ooo_cpc0", commit_pc, 0);

    // 3: wrap-around
    flush = 1'b1; tick(); flush = 1'b0;
    for (int n = 0; n < 62; n++) alloc(6'(n), 6'(n), 32'(n));
    for (int n = 0; n < 62; n++) cpl1(6'(n));
    commit_ready = 1'b1;
    for (int n = 0; n < 62; n++) tick();
    commit_ready = 1'b0;
    chk("wrap_count0", count, 0);
    for (int k = 0; k < 4; k++) begin
      chk("wrap_tag", alloc_tag, (64'd62 + 64'(k)) % 64);
      alloc(6'd40 + 6'(k), 6'd10 + 6'(k), 32'h300 + 32'(k));
    end
    cpl_valid = 2'b11; cpl_tag = {6'd63, 6'd62}; tick();
    cpl_tag = {6'd1, 6'd0}; tick();
    cpl_valid = 2'b00;
    commit_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("wrap_cvalid", commit_valid, 1);
      chk("wrap_old", commit_old_destreg, 64'd10 + 64'(k));
      tick();
    end
    commit_ready = 1'b0;
    chk("wrap_empty", empty, 1);

    // 4: alloc+commit while full; head/tail both at 2
    for (int n = 0; n < DEPTH; n++) alloc(6'(n), 6'(n), 32'h400 + 32'(n));
    cpl1(6'd2);
    alloc_valid = 1'b1; alloc_pc = 32'hABC; commit_ready = 1'b1;
    chk("full_cvalid", commit_valid, 1);
    chk("full_ready", alloc_ready, 0);
    tick();
    commit_ready = 1'b0;
    chk("full_count63", count, 63);
    chk("full_ready1", alloc_ready, 1);
    chk("full_tag", alloc_tag, 2);
    tick();
    alloc_valid = 1'b0;
    chk("full_count64", count, 64);
    chk("full_newhead", commit_valid, 0);

    // 5: dual-channel same tag, stale tag 9
    flush = 1'b1; tick(); flush = 1'b0;
    for (int n = 0; n < 6; n++) alloc(6'(n), 6'(n), 32'h500 + 32'(4 * n));
    cpl_valid = 2'b11; cpl_tag = {6'd5, 6'd5}; tick();
    cpl1(6'd9);
    for (int n = 0; n < 5; n++) cpl1(6'(n));
    commit_ready = 1'b1;
    for (int n = 0; n < 6; n++) begin
      chk("dual_pc", commit_pc, 32'h500 + 64'(4 * n));
      tick();
    end
    commit_ready = 1'b0;
    chk("dual_empty", empty, 1);
    for (int n = 6; n < 10; n++) alloc(6'(n), 6'(n), 32'h600);
    for (int n = 6; n < 9; n++) cpl1(6'(n));
    commit_ready = 1'b1;
    for (int n = 0; n < 3; n++) tick();
    commit_ready = 1'b0;
    chk("stale_cvalid", commit_valid, 0);
    chk("stale_count", count, 1);

    // 6: flush with alloc and commit pending, then async reset
    for (int n = 10; n < 19; n++) alloc(6'(n), 6'(n), 32'h700);
    cpl1(6'd9);
    chk("fl_count10", count, 10);
    chk("fl_cvalid", commit_valid, 1);
    flush = 1'b1; alloc_valid = 1'b1; commit_ready = 1'b1;
    tick();
    flush = 1'b0; alloc_valid = 1'b0; commit_ready = 1'b0;
    chk("fl_count", count, 0);
    chk("fl_empty", empty, 1);
    chk("fl_tag", alloc_tag, 0);
    chk("fl_cvalid0", commit_valid, 0);
    alloc(6'd1, 6'd1, 32'h800);
    alloc(6'd2, 6'd2, 32'h804);
    cpl1(6'd0);
    chk("pre_rst_cvalid", commit_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_count", count, 0);
    chk("arst_empty", empty, 1);
    chk("arst_tag", alloc_tag, 0);
    chk("arst_cvalid", commit_valid, 0);
    chk("arst_cpc", commit_pc, 0);
    chk("arst_ready", alloc_ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rob_buffer.md
Name: rob_buffer

Overview:
- Parametrised reorder buffer for the out-of-order core.
- Replaces the fixed 64-entry ROB record with a self-contained circular buffer: in-order allocation from rename/dispatch, out-of-order completion from NUM_CPL functional-unit writeback channels, in-order commit to retire, and a full flush on mispredict/exception.
- Sits between the rename stage, the reservation-station table (which stores alloc_tag per entry) and the retire/free-list logic.

Parameters:
- DEPTH, 64, number of ROB entries; power of two, 4..256.
- TAG_W, $clog2(DEPTH), entry index width (derived; do not override).
- PREG_W, 6, physical register index width.
- PC_W, 32, program counter width.
- NUM_CPL, 2, number of independent completion channels.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous squash of every entry.
- alloc_valid  in  1  rename presents an instruction.
- alloc_ready  out  1  entry available (!full).
- alloc_destreg  in  PREG_W  new physical destination.
- alloc_old_destreg  in  PREG_W  previous mapping of the architectural destination.
- alloc_pc  in  PC_W  instruction PC.
- alloc_tag  out  TAG_W  index the entry is written to (= tail).
- cpl_valid  in  NUM_CPL  per-channel completion strobe.
- cpl_tag  in  NUM_CPL*TAG_W  packed tags; channel i at bits [i*TAG_W +: TAG_W].
- commit_valid  out  1  head entry is allocated and completed.
- commit_ready  in  1  retire accepts the head entry.
- commit_destreg  out  PREG_W  head destreg.
- commit_old_destreg  out  PREG_W  head old_destreg, to be freed.
- commit_pc  out  PC_W  head pc.
- count  out  $clog2(DEPTH+1)  occupied entries.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.

Behaviour:
- **State:** per-entry used, completed, destreg, old_destreg, pc; head and tail pointers of TAG_W bits; count register.
- **Reset (async):**
  - All used/completed bits = 0; head = tail = count = 0.
  - Outputs: alloc_ready=1, alloc_tag=0, commit_valid=0, commit data=0, count=0, full=0, empty=1.
  - Reset asserted mid-operation discards all entries immediately.
- **Allocate:** on alloc_valid && alloc_ready:
  - entry[tail] gets used=1, completed=0 and the three fields.
  - tail increments modulo DEPTH, wrapping naturally at DEPTH-1 -> 0.
  - alloc_tag is combinational from tail and is valid in the same cycle.
- **alloc_ready** = !full, computed from the registered count. A commit in the same cycle does not free a slot for allocation until the next cycle.
- **Complete:** for each channel i with cpl_valid[i], set completed[cpl_tag_i] = 1, but only if used[cpl_tag_i] is set; otherwise ignore. Two channels naming the same tag is legal (idempotent).
- **Commit:**
  - commit_valid = used[head] && completed[head], combinational from registered state.
  - A completion is visible on commit_valid one cycle after its strobe.
  - commit_* data equals entry[head] fields when commit_valid=1, else 0.
  - On commit_valid && commit_ready: clear used[head] and completed[head]; head increments modulo DEPTH.
- **count** next value = count + alloc_fire - commit_fire. Simultaneous alloc and commit leaves count unchanged. full/empty are derived from count.
- **Flush:**
  - Clears every used/completed bit and sets head = tail = count = 0 at the clock edge.
  - Takes priority over alloc, complete and commit in the same cycle; those same-cycle handshakes are dropped.
- Entry fields (destreg/old_destreg/pc) need no reset; only the valid bits are reset.
- No combinational path from alloc_valid or cpl_valid to any output.

Test Plan:
1. **Reset then fill:** after rst, alloc 64 instrs with pc=0x100+4n. Required: alloc_tag 0..63, full=1 and alloc_ready=0 after the 64th, count=64.
2. **Out-of-order completion:** alloc tags 0,1,2; complete tag 2 then 1. Required: commit_valid stays 0. Complete tag 0; next cycle commit_valid=1 with pc of tag0; with commit_ready=1, commits 0,1,2 on three consecutive cycles, then empty=1.
3. **Wrap-around:** alloc/commit 62 entries, then alloc 4. Required: tags 62,63,0,1; committing all four yields them in that order with correct old_destreg.
4. **Simultaneous alloc+commit while full:** full buffer, head completed, alloc_valid=1, commit_ready=1. Required: commit fires, alloc rejected (alloc_ready=0), count=63; next cycle alloc accepted at tag = old head.
5. **Dual-channel completion and stale tag:** cpl_valid=2'b11 with both tags =5 (allocated) → entry 5 completed once; cpl on an unallocated tag 9 → no state change, commit_valid stays 0 for tag 9 after its later allocation.
6. **Flush and async reset:** flush with 10 entries while alloc_valid=1 and commit fire pending. Required: next cycle count=0, empty=1, alloc_tag=0, nothing committed. Assert rst mid-cycle → outputs reach reset values without waiting for a clock edge.
